// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge capture of four sources, maskable pending
// flags, fixed-priority (lowest index) dispatch and a non-nesting service FSM
// that drives one-cycle entry/resume strobes to the datapath.
module irq_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    parameter logic [3:0]  MASK_RST   = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  irq_src,
    input  logic        mask_we,
    input  logic [3:0]  mask_wd,
    input  logic        eret,
    output logic        irq_entry,
    output logic        irq_resume,
    output logic [31:0] irq_addr,
    output logic [1:0]  irq_cause,
    output logic        irq_busy,
    output logic [3:0]  irq_pending,
    output logic [3:0]  irq_mask
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StEntry   = 2'd1,
        StService = 2'd2,
        StResume  = 2'd3
    } state_e;

    state_e      state_q, state_d;

    logic [3:0]  src_q;
    logic [3:0]  src_edge;
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  eligible;
    logic [3:0]  win_onehot;
    logic [1:0]  win_idx;
    logic        dispatch;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  cause_q, cause_d;
    logic        entry_q, resume_q, busy_q;

    // A source counts as an edge when high now and low in the previous sample.
    assign src_edge = irq_src & ~src_q;

    // Only unmasked pending sources compete; the old mask applies this cycle.
    assign eligible = pend_q & mask_q;

    // Lowest set index wins: scan downwards so the smallest index is written last.
    always_comb begin
        win_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = 2'(i);
            end
        end
        win_onehot = 4'b0001 << win_idx;
    end

    // Service FSM next-state; dispatch only happens from idle, so no nesting.
    always_comb begin
        state_d  = state_q;
        dispatch = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    dispatch = 1'b1;
                    state_d  = StEntry;
                end
            end
            StEntry: begin
                state_d = StService;
            end
            StService: begin
                if (eret) begin
                    state_d = StResume;
                end
            end
            StResume: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pending, mask and vector next-state; a fresh edge beats the dispatch clear.
    always_comb begin
        pend_d  = pend_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        cause_d = cause_q;
        if (dispatch) begin
            pend_d  = pend_q & ~win_onehot;
            addr_d  = BASE_ADDR + (VEC_STRIDE * 32'(win_idx));
            cause_d = win_idx;
        end
        pend_d = pend_d | src_edge;
        if (mask_we) begin
            mask_d = mask_wd;
        end
    end

    // State and datapath registers; strobes are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            src_q    <= 4'b0000;
            pend_q   <= 4'b0000;
            mask_q   <= MASK_RST;
            addr_q   <= 32'h0000_0000;
            cause_q  <= 2'd0;
            entry_q  <= 1'b0;
            resume_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= irq_src;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            cause_q  <= cause_d;
            entry_q  <= (state_d == StEntry);
            resume_q <= (state_d == StResume);
            busy_q   <= (state_d != StIdle);
        end
    end

    assign irq_entry   = entry_q;
    assign irq_resume  = resume_q;
    assign irq_addr    = addr_q;
    assign irq_cause   = cause_q;
    assign irq_busy    = busy_q;
    assign irq_pending = pend_q;
    assign irq_mask    = mask_q;

endmodule
